// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare direction predictor: default widths,
// the table-controller state type and the prediction record carried by fetch.
package gshare_predictor_pkg;

    localparam int GSHARE_XLEN            = 32;
    localparam int GSHARE_GHSR_WIDTH      = 10;
    localparam int GSHARE_PHT_INDEX_WIDTH = 10;
    localparam int GSHARE_CTR_WIDTH       = 2;
    localparam int GSHARE_HASH_MODE       = 0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } gshare_ctr_state;

    // Prediction record that travels with a fetched branch down to EX.
    typedef struct packed {
        logic                         taken;
        logic [GSHARE_GHSR_WIDTH-1:0] current_GHSR;
    } branch_predict_type;

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: counter array with two combinational read ports
// (fetch lookup and update read-modify-write) and one synchronous write port.
module gshare_pht #(
    parameter int INDEX_WIDTH = 10,
    parameter int CTR_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic [INDEX_WIDTH-1:0] lookup_idx,
    output logic [CTR_WIDTH-1:0]   lookup_ctr,
    input  logic [INDEX_WIDTH-1:0] upd_idx,
    output logic [CTR_WIDTH-1:0]   upd_ctr,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [CTR_WIDTH-1:0]   wr_data
);

    logic [CTR_WIDTH-1:0] mem [2**INDEX_WIDTH];

    // NOTE: the array has no reset on purpose; the init sweep fills it, and a
    // reset-free array can map onto RAM instead of thousands of flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Reads are asynchronous, so a same-cycle write is not seen until the next cycle.
    assign lookup_ctr = mem[lookup_idx];
    assign upd_ctr    = mem[upd_idx];

endmodule

// File: rtl/gshare_predictor.sv
// Parametrised gshare/bimodal direction predictor with a table init sweep,
// speculative global history and mispredict recovery.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int XLEN            = GSHARE_XLEN,
    parameter int GHSR_WIDTH      = GSHARE_GHSR_WIDTH,
    parameter int PHT_INDEX_WIDTH = GSHARE_PHT_INDEX_WIDTH,
    parameter int CTR_WIDTH       = GSHARE_CTR_WIDTH,
    parameter int HASH_MODE       = GSHARE_HASH_MODE
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready_o,
    input  logic                  pht_flush_i,
    input  logic [XLEN-1:0]       pred_pc_i,
    output logic                  pred_taken_o,
    output logic [GHSR_WIDTH-1:0] pred_ghsr_o,
    input  logic                  pred_spec_i,
    input  logic                  upd_valid_i,
    input  logic [XLEN-1:0]       upd_pc_i,
    input  logic [GHSR_WIDTH-1:0] upd_ghsr_i,
    input  logic                  upd_taken_i,
    input  logic                  upd_mispredict_i
);

    localparam int HIST_EXT_WIDTH = (GHSR_WIDTH > PHT_INDEX_WIDTH) ? GHSR_WIDTH : PHT_INDEX_WIDTH;
    localparam logic [PHT_INDEX_WIDTH-1:0] PHT_LAST    = '1;
    localparam logic [CTR_WIDTH-1:0]       CTR_MAX     = '1;
    localparam logic [CTR_WIDTH-1:0]       CTR_WEAK_NT = {1'b0, {(CTR_WIDTH-1){1'b1}}};

    gshare_ctr_state             state, state_next;
    logic [PHT_INDEX_WIDTH-1:0]  init_idx, init_idx_next;
    logic [GHSR_WIDTH-1:0]       ghsr, ghsr_next;

    logic [PHT_INDEX_WIDTH-1:0]  lookup_idx, upd_idx, wr_idx;
    logic [CTR_WIDTH-1:0]        lookup_ctr, upd_ctr, upd_ctr_next, wr_data;
    logic                        wr_en;

    // History is zero-extended or truncated to the index width before hashing.
    function automatic logic [PHT_INDEX_WIDTH-1:0] pht_index(
        input logic [XLEN-1:0]       pc,
        input logic [GHSR_WIDTH-1:0] hist
    );
        logic [HIST_EXT_WIDTH-1:0] hist_ext;
        hist_ext = HIST_EXT_WIDTH'(hist);
        if (HASH_MODE == 0) begin
            return hist_ext[PHT_INDEX_WIDTH-1:0] ^ pc[PHT_INDEX_WIDTH+1:2];
        end
        return pc[PHT_INDEX_WIDTH+1:2];
    endfunction

    assign lookup_idx = pht_index(pred_pc_i, ghsr);
    assign upd_idx    = pht_index(upd_pc_i, upd_ghsr_i);

    gshare_pht #(
        .INDEX_WIDTH (PHT_INDEX_WIDTH),
        .CTR_WIDTH   (CTR_WIDTH)
    ) u_pht (
        .clk        (clk),
        .lookup_idx (lookup_idx),
        .lookup_ctr (lookup_ctr),
        .upd_idx    (upd_idx),
        .upd_ctr    (upd_ctr),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data)
    );

    assign ready_o      = (state == RUN);
    assign pred_taken_o = ready_o & lookup_ctr[CTR_WIDTH-1];
    assign pred_ghsr_o  = ghsr;

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (upd_taken_i) begin
            if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_WIDTH'(1);
        end else begin
            if (upd_ctr != '0) upd_ctr_next = upd_ctr - CTR_WIDTH'(1);
        end
    end

    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next    = state;
        init_idx_next = init_idx;
        ghsr_next     = ghsr;
        wr_en         = 1'b0;
        wr_idx        = upd_idx;
        wr_data       = upd_ctr_next;

        unique case (state)
            INIT: begin
                wr_en         = 1'b1;
                wr_idx        = init_idx;
                wr_data       = CTR_WEAK_NT;
                init_idx_next = init_idx + PHT_INDEX_WIDTH'(1);
                if (init_idx == PHT_LAST) state_next = RUN;
            end
            RUN: begin
                wr_en = upd_valid_i;
                if (upd_valid_i && upd_mispredict_i) begin
                    ghsr_next = {upd_ghsr_i[GHSR_WIDTH-2:0], upd_taken_i};
                end else if (pred_spec_i) begin
                    ghsr_next = {ghsr[GHSR_WIDTH-2:0], pred_taken_o};
                end
            end
            default: state_next = INIT;
        endcase

        // A flush discards any same-cycle update; the sweep rewrites the table anyway.
        if (pht_flush_i) begin
            state_next    = INIT;
            init_idx_next = '0;
            ghsr_next     = '0;
            wr_en         = (state == INIT);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_idx <= '0;
            ghsr     <= '0;
        end else begin
            state    <= state_next;
            init_idx <= init_idx_next;
            ghsr     <= ghsr_next;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[1:0], pred_pc_i[XLEN-1:PHT_INDEX_WIDTH+2],
                              upd_pc_i[1:0], upd_pc_i[XLEN-1:PHT_INDEX_WIDTH+2]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: default gshare instance plus a
// bimodal 12-bit-history / 256-entry / 3-bit-counter instance.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;

    logic        pht_flush, pred_spec, upd_valid, upd_taken, upd_mispredict;
    logic [31:0] pred_pc, upd_pc;
    logic [9:0]  upd_ghsr;
    logic        ready, pred_taken;
    logic [9:0]  pred_ghsr;

    logic        a_flush, a_pred_spec, a_upd_valid, a_upd_taken, a_upd_mispredict;
    logic [31:0] a_pred_pc, a_upd_pc;
    logic [11:0] a_upd_ghsr;
    logic        a_ready, a_pred_taken;
    logic [11:0] a_pred_ghsr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .ready_o          (ready),
        .pht_flush_i      (pht_flush),
        .pred_pc_i        (pred_pc),
        .pred_taken_o     (pred_taken),
        .pred_ghsr_o      (pred_ghsr),
        .pred_spec_i      (pred_spec),
        .upd_valid_i      (upd_valid),
        .upd_pc_i         (upd_pc),
        .upd_ghsr_i       (upd_ghsr),
        .upd_taken_i      (upd_taken),
        .upd_mispredict_i (upd_mispredict)
    );

    gshare_predictor #(
        .XLEN            (32),
        .GHSR_WIDTH      (12),
        .PHT_INDEX_WIDTH (8),
        .CTR_WIDTH       (3),
        .HASH_MODE       (1)
    ) alt_dut (
        .clk              (clk),
        .reset            (reset),
        .ready_o          (a_ready),
        .pht_flush_i      (a_flush),
        .pred_pc_i        (a_pred_pc),
        .pred_taken_o     (a_pred_taken),
        .pred_ghsr_o      (a_pred_ghsr),
        .pred_spec_i      (a_pred_spec),
        .upd_valid_i      (a_upd_valid),
        .upd_pc_i         (a_upd_pc),
        .upd_ghsr_i       (a_upd_ghsr),
        .upd_taken_i      (a_upd_taken),
        .upd_mispredict_i (a_upd_mispredict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_main();
        pht_flush = 0; pred_spec = 0; upd_valid = 0; upd_taken = 0; upd_mispredict = 0;
        pred_pc = 0; upd_pc = 0; upd_ghsr = 0;
    endtask

    initial begin
        int main_rdy, alt_rdy, cyc;
        logic pred_seen;

        clear_main();
        a_flush = 0; a_pred_spec = 0; a_upd_valid = 0; a_upd_taken = 0; a_upd_mispredict = 0;
        a_pred_pc = 0; a_upd_pc = 0; a_upd_ghsr = 0;
        reset = 1;
        tick();
        tick();
        check("reset_ready", ready, 0);
        check("reset_pred_taken", pred_taken, 0);
        check("reset_ghsr", pred_ghsr, 0);
        check("reset_alt_ready", a_ready, 0);

        // Initial sweep after reset release
        reset = 0;
        main_rdy = -1; alt_rdy = -1; pred_seen = 0;
        for (int c = 1; c <= 1100 && main_rdy < 0; c++) begin
            pred_pc = $urandom;
            #1;
            if (pred_taken) pred_seen = 1;
            tick();
            if (a_ready && alt_rdy < 0) alt_rdy = c;
            if (ready && main_rdy < 0) main_rdy = c;
        end
        pred_pc = 0;
        check("sweep_ready_cycles", main_rdy, 1024);
        check("alt_sweep_ready_cycles", alt_rdy, 256);
        check("sweep_pred_forced_low", pred_seen, 0);
        check("init_ctr_0x000", dut.u_pht.mem[10'h000], 2'b01);
        check("init_ctr_0x040", dut.u_pht.mem[10'h040], 2'b01);
        check("init_ctr_0x3ff", dut.u_pht.mem[10'h3FF], 2'b01);
        pred_pc = 32'h100;
        #1;
        check("init_lookup_0x100", pred_taken, 0);

        // Two taken updates at pc 0x100 (index 0x040); same-cycle lookup sees old value
        upd_valid = 1; upd_pc = 32'h100; upd_ghsr = 0; upd_taken = 1; upd_mispredict = 0;
        #1;
        check("no_bypass_lookup", pred_taken, 0);
        tick();
        check("train_t1_ctr", dut.u_pht.mem[10'h040], 2'b10);
        check("train_t1_pred", pred_taken, 1);
        tick();
        check("train_t2_ctr", dut.u_pht.mem[10'h040], 2'b11);
        check("train_t2_pred", pred_taken, 1);
        check("correct_update_keeps_ghsr", pred_ghsr, 0);
        tick();
        check("train_t3_sat_ctr", dut.u_pht.mem[10'h040], 2'b11);

        // Not-taken down to zero and saturate
        upd_taken = 0;
        tick();
        check("nt1_ctr", dut.u_pht.mem[10'h040], 2'b10);
        check("nt1_pred", pred_taken, 1);
        tick();
        check("nt2_ctr", dut.u_pht.mem[10'h040], 2'b01);
        check("nt2_pred", pred_taken, 0);
        tick();
        check("nt3_ctr", dut.u_pht.mem[10'h040], 2'b00);
        tick();
        check("nt4_sat_ctr", dut.u_pht.mem[10'h040], 2'b00);
        check("nt4_pred", pred_taken, 0);
        upd_valid = 0;

        // Recovery to 0x155 (also trains index 0x0AA to 10), then speculative shift
        upd_valid = 1; upd_mispredict = 1; upd_pc = 0; upd_ghsr = 10'h0AA; upd_taken = 1;
        tick();
        upd_valid = 0; upd_mispredict = 0;
        check("recover_ghsr_0x155", pred_ghsr, 10'h155);
        check("recover_ctr_0x0aa", dut.u_pht.mem[10'h0AA], 2'b10);
        pred_pc = 32'h7FC;
        #1;
        check("hashed_lookup_taken", pred_taken, 1);
        pred_spec = 1;
        tick();
        pred_spec = 0;
        check("spec_shift_ghsr", pred_ghsr, 10'h2AB);

        upd_valid = 1; upd_mispredict = 1; upd_pc = 0; upd_ghsr = 10'h0AA; upd_taken = 1;
        tick();
        check("recover_again_ghsr", pred_ghsr, 10'h155);
        check("recover_again_ctr", dut.u_pht.mem[10'h0AA], 2'b11);
        pred_pc = 32'h7FC; pred_spec = 1;
        upd_valid = 1; upd_mispredict = 1; upd_pc = 0; upd_ghsr = 10'h001; upd_taken = 0;
        #1;
        check("simul_pred_taken", pred_taken, 1);
        tick();
        clear_main();
        check("recovery_beats_spec", pred_ghsr, 10'h002);
        check("recovery_ctr_0x001", dut.u_pht.mem[10'h001], 2'b00);
        pred_pc = 0; pred_spec = 1;
        #1;
        check("spec_nt_pred", pred_taken, 0);
        tick();
        pred_spec = 0;
        check("spec_nt_ghsr", pred_ghsr, 10'h004);

        // Bimodal instance: 3-bit counters, index from PC only
        check("alt_init_ctr_5", alt_dut.u_pht.mem[8'h05], 3'b011);
        check("alt_init_ctr_ff", alt_dut.u_pht.mem[8'hFF], 3'b011);
        a_upd_valid = 1; a_upd_mispredict = 1; a_upd_pc = 32'h14; a_upd_ghsr = 12'hABC; a_upd_taken = 1;
        tick();
        a_upd_mispredict = 0;
        check("alt_recover_ghsr", a_pred_ghsr, 12'h579);
        check("alt_t1_ctr", alt_dut.u_pht.mem[8'h05], 3'b100);
        for (int k = 0; k < 4; k++) begin
            a_upd_ghsr = 12'h100 + 12'(k);
            tick();
        end
        check("alt_sat_high", alt_dut.u_pht.mem[8'h05], 3'b111);
        a_upd_valid = 0;
        a_pred_pc = 32'h14;
        #1;
        check("alt_pred_ignores_ghsr", a_pred_taken, 1);
        a_pred_pc = 32'h18;
        #1;
        check("alt_pred_other_idx", a_pred_taken, 0);
        a_upd_valid = 1; a_upd_taken = 0; a_upd_ghsr = 12'h123;
        for (int k = 1; k <= 8; k++) begin
            tick();
            a_upd_ghsr = a_upd_ghsr + 12'h111;
            if (k == 4 || k >= 7) check("alt_nt_ctr", alt_dut.u_pht.mem[8'h05], (k >= 7) ? 3'b000 : 3'b011);
        end
        a_upd_valid = 0;
        a_pred_pc = 32'h14;
        #1;
        check("alt_pred_after_nt", a_pred_taken, 0);

        // Flush in RUN, junk traffic during the sweep, re-flush mid-sweep
        pht_flush = 1;
        tick();
        pht_flush = 0;
        check("flush_ready_low", ready, 0);
        check("flush_ghsr_clear", pred_ghsr, 0);
        upd_valid = 1; upd_mispredict = 1; upd_ghsr = 10'h3FF; upd_taken = 1; upd_pc = 0;
        pred_spec = 1; pred_pc = 32'h100;
        for (int k = 0; k < 500; k++) tick();
        pht_flush = 1;
        tick();
        pht_flush = 0;
        check("reflush_ready_low", ready, 0);
        cyc = -1;
        for (int c = 1; c <= 1100 && cyc < 0; c++) begin
            tick();
            if (ready) cyc = c;
        end
        clear_main();
        check("reflush_ready_cycles", cyc, 1024);
        check("flush_ghsr_after", pred_ghsr, 0);
        check("flush_ctr_0x040", dut.u_pht.mem[10'h040], 2'b01);
        check("flush_ctr_0x0aa", dut.u_pht.mem[10'h0AA], 2'b01);
        check("flush_ctr_0x001", dut.u_pht.mem[10'h001], 2'b01);
        check("flush_ctr_0x3ff", dut.u_pht.mem[10'h3FF], 2'b01);

        // Asynchronous reset in the middle of operation
        upd_valid = 1; upd_mispredict = 1; upd_ghsr = 10'h0F0; upd_taken = 1;
        tick();
        clear_main();
        check("pre_reset_ghsr", pred_ghsr, 10'h1E1);
        #2;
        reset = 1;
        #1;
        check("midrun_reset_ready", ready, 0);
        check("midrun_reset_ghsr", pred_ghsr, 0);
        check("midrun_reset_alt_ready", a_ready, 0);
        tick();
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
